// File: rtl/ansi_term_pkg.sv
// Shared constants for the ANSI terminal byte parser: opcodes, FSM state
// encoding, control bytes and the CSI parameter accumulator.
package ansi_term_pkg;

  localparam logic [3:0] OP_NOP        = 4'd0;
  localparam logic [3:0] OP_PUT        = 4'd1;
  localparam logic [3:0] OP_CR         = 4'd2;
  localparam logic [3:0] OP_LF         = 4'd3;
  localparam logic [3:0] OP_BS         = 4'd4;
  localparam logic [3:0] OP_TAB        = 4'd5;
  localparam logic [3:0] OP_HOME       = 4'd6;
  localparam logic [3:0] OP_MOVE_UP    = 4'd7;
  localparam logic [3:0] OP_MOVE_DOWN  = 4'd8;
  localparam logic [3:0] OP_MOVE_RIGHT = 4'd9;
  localparam logic [3:0] OP_MOVE_LEFT  = 4'd10;
  localparam logic [3:0] OP_GOTO       = 4'd11;
  localparam logic [3:0] OP_CLEAR      = 4'd12;
  localparam logic [3:0] OP_CLEAR_EOL  = 4'd13;
  localparam logic [3:0] OP_COLOR      = 4'd14;

  localparam logic [1:0] ST_GROUND = 2'd0;
  localparam logic [1:0] ST_ESC    = 2'd1;
  localparam logic [1:0] ST_CSI    = 2'd2;

  localparam logic [7:0] B_SOH    = 8'h01;
  localparam logic [7:0] B_BS     = 8'h08;
  localparam logic [7:0] B_TAB    = 8'h09;
  localparam logic [7:0] B_LF     = 8'h0A;
  localparam logic [7:0] B_CR     = 8'h0D;
  localparam logic [7:0] B_CAN    = 8'h18;
  localparam logic [7:0] B_SUB    = 8'h1A;
  localparam logic [7:0] B_ESC    = 8'h1B;
  localparam logic [7:0] B_DEL    = 8'h7F;
  localparam logic [7:0] B_LBRACK = 8'h5B;
  localparam logic [7:0] B_SEMI   = 8'h3B;

  // Decimal accumulate, saturating at 255 so long digit runs cannot wrap.
  function automatic logic [7:0] param_acc(input logic [7:0] p, input logic [3:0] d);
    logic [11:0] sum;
    sum = (12'(p) * 12'd10) + 12'(d);
    if (sum > 12'd255) begin
      param_acc = 8'hFF;
    end else begin
      param_acc = sum[7:0];
    end
  endfunction

  function automatic logic [7:0] one_if_zero(input logic [7:0] p);
    if (p == 8'd0) begin
      one_if_zero = 8'd1;
    end else begin
      one_if_zero = p;
    end
  endfunction

endpackage

// File: rtl/term_byte_fifo.sv
// Synchronous FIFO with full/empty flags. A push while full is accepted only
// when a pop frees the slot in the same cycle.
module term_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_s, pop_s;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign pop_s     = rd_en_i && !empty_o;
  assign push_s    = wr_en_i && (!full_o || pop_s);
  assign rd_data_o = mem_q[rd_ptr_q];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ansi_term_parser.sv
// UART byte stream to terminal command decoder (PUT, C0 controls, CSI cursor,
// GOTO, clear). CSI 'm' colour selection is built only with ANSI_SGR_EN.
module ansi_term_parser
  import ansi_term_pkg::*;
#(
  parameter int COLS       = 160,
  parameter int ROWS       = 90,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_pixel,
  input  logic       rst_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [3:0] cmd_op,
  output logic [6:0] cmd_char,
  output logic [7:0] cmd_arg0,
  output logic [7:0] cmd_arg1,
  output logic       overflow
);

  localparam logic [7:0] COLS_C = 8'(COLS);
  localparam logic [7:0] ROWS_C = 8'(ROWS);

  logic [7:0] byte_s;
  logic       fifo_full_s, fifo_empty_s, pop_s;
  logic [1:0] state_q, state_d, idx_q, idx_d;
  logic [7:0] p0_q, p0_d, p1_q, p1_d, p0_eff_s, p1_eff_s, row_s, col_s;
  logic       emit_s;
  logic [3:0] op_s, op_q, op_d;
  logic [6:0] char_s, char_q, char_d;
  logic [7:0] arg0_s, arg1_s, arg0_q, arg0_d, arg1_q, arg1_d;
  logic       valid_q, valid_d, ovf_q, ovf_d;

  // A byte may be consumed only when the command slot is free or being drained.
  assign pop_s = !fifo_empty_s && (!valid_q || cmd_ready);

  term_byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk       (clk_pixel),
    .rst_n     (rst_n),
    .wr_en_i   (rx_valid),
    .wr_data_i (rx_byte),
    .rd_en_i   (pop_s),
    .rd_data_o (byte_s),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s)
  );

  assign p0_eff_s = one_if_zero(p0_q);
  assign p1_eff_s = one_if_zero(p1_q);
  assign row_s    = ((p0_eff_s > ROWS_C) ? ROWS_C : p0_eff_s) - 8'd1;
  assign col_s    = ((p1_eff_s > COLS_C) ? COLS_C : p1_eff_s) - 8'd1;

  // Lexer FSM, parameter accumulation and command decode for the popped byte.
  always_comb begin
    state_d = state_q;
    p0_d    = p0_q;
    p1_d    = p1_q;
    idx_d   = idx_q;
    emit_s  = 1'b0;
    op_s    = OP_NOP;
    char_s  = 7'd0;
    arg0_s  = 8'd0;
    arg1_s  = 8'd0;
    if (pop_s) begin
      case (state_q)
        ST_GROUND: begin
          if (byte_s >= 8'h20 && byte_s <= 8'h7E) begin
            emit_s = 1'b1;
            op_s   = OP_PUT;
            char_s = byte_s[6:0];
          end else begin
            case (byte_s)
              B_CR:          begin emit_s = 1'b1; op_s = OP_CR;   end
              B_LF:          begin emit_s = 1'b1; op_s = OP_LF;   end
              B_BS, B_DEL:   begin emit_s = 1'b1; op_s = OP_BS;   end
              B_TAB:         begin emit_s = 1'b1; op_s = OP_TAB;  end
              B_SOH:         begin emit_s = 1'b1; op_s = OP_HOME; end
              B_ESC:         state_d = ST_ESC;
              default:       state_d = ST_GROUND;
            endcase
          end
        end
        ST_ESC: begin
          if (byte_s == B_LBRACK) begin
            state_d = ST_CSI;
            p0_d    = 8'd0;
            p1_d    = 8'd0;
            idx_d   = 2'd0;
          end else if (byte_s == B_ESC) begin
            state_d = ST_ESC;
          end else begin
            state_d = ST_GROUND;
          end
        end
        ST_CSI: begin
          if (byte_s >= 8'h30 && byte_s <= 8'h39) begin
            if (idx_q == 2'd0) begin
              p0_d = param_acc(p0_q, byte_s[3:0]);
            end else if (idx_q == 2'd1) begin
              p1_d = param_acc(p1_q, byte_s[3:0]);
            end else begin
              p0_d = p0_q;
            end
          end else if (byte_s == B_SEMI) begin
            idx_d = (idx_q == 2'd2) ? 2'd2 : idx_q + 2'd1;
          end else if (byte_s >= 8'h40 && byte_s <= 8'h7E) begin
            state_d = ST_GROUND;
            case (byte_s)
              8'h41: begin emit_s = 1'b1; op_s = OP_MOVE_UP;    arg0_s = p0_eff_s; end
              8'h42: begin emit_s = 1'b1; op_s = OP_MOVE_DOWN;  arg0_s = p0_eff_s; end
              8'h43: begin emit_s = 1'b1; op_s = OP_MOVE_RIGHT; arg0_s = p0_eff_s; end
              8'h44: begin emit_s = 1'b1; op_s = OP_MOVE_LEFT;  arg0_s = p0_eff_s; end
              8'h48, 8'h66: begin
                emit_s = 1'b1;
                op_s   = OP_GOTO;
                arg0_s = col_s;
                arg1_s = row_s;
              end
              8'h4A: begin emit_s = (p0_q == 8'd2); op_s = OP_CLEAR;     end
              8'h4B: begin emit_s = (p0_q == 8'd0); op_s = OP_CLEAR_EOL; end
`ifdef ANSI_SGR_EN
              8'h6D: begin
                op_s = OP_COLOR;
                if (p0_q == 8'd0) begin
                  emit_s = 1'b1;
                  arg0_s = 8'd2;
                end else if (p0_q >= 8'd30 && p0_q <= 8'd37) begin
                  emit_s = 1'b1;
                  arg0_s = p0_q - 8'd30;
                end else begin
                  emit_s = 1'b0;
                end
              end
`endif
              default: emit_s = 1'b0;
            endcase
          end else if (byte_s == B_ESC) begin
            state_d = ST_ESC;
          end else begin
            state_d = ST_GROUND;
          end
        end
        default: state_d = ST_GROUND;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Command slot: load on a decoding pop, clear after an idle handshake, else hold.
  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    char_d  = char_q;
    arg0_d  = arg0_q;
    arg1_d  = arg1_q;
    ovf_d   = ovf_q | (rx_valid & fifo_full_s & ~pop_s);
    if (pop_s && emit_s) begin
      valid_d = 1'b1;
      op_d    = op_s;
      char_d  = char_s;
      arg0_d  = arg0_s;
      arg1_d  = arg1_s;
    end else if (valid_q && cmd_ready) begin
      valid_d = 1'b0;
      op_d    = OP_NOP;
      char_d  = 7'd0;
      arg0_d  = 8'd0;
      arg1_d  = 8'd0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_GROUND;
      idx_q   <= 2'd0;
      p0_q    <= 8'd0;
      p1_q    <= 8'd0;
      valid_q <= 1'b0;
      op_q    <= OP_NOP;
      char_q  <= 7'd0;
      arg0_q  <= 8'd0;
      arg1_q  <= 8'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      valid_q <= valid_d;
      op_q    <= op_d;
      char_q  <= char_d;
      arg0_q  <= arg0_d;
      arg1_q  <= arg1_d;
      ovf_q   <= ovf_d;
    end
  end

  assign cmd_valid = valid_q;
  assign cmd_op    = op_q;
  assign cmd_char  = char_q;
  assign cmd_arg0  = arg0_q;
  assign cmd_arg1  = arg1_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_ansi_term_parser.sv
// Scoreboard bench for ansi_term_parser: directed byte streams push expected
// commands; a monitor pops and compares on every accepted command.
module tb_ansi_term_parser;
  import ansi_term_pkg::*;

  typedef struct packed {
    logic [3:0] op;
    logic [6:0] ch;
    logic [7:0] a0;
    logic [7:0] a1;
  } cmd_t;

  logic       clk_pixel = 1'b0;
  logic       rst_n;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [6:0] cmd_char;
  logic [7:0] cmd_arg0, cmd_arg1;
  logic       overflow;

  cmd_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  ansi_term_parser #(.COLS(160), .ROWS(90), .FIFO_DEPTH(4)) dut (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_char  (cmd_char),
    .cmd_arg0  (cmd_arg0),
    .cmd_arg1  (cmd_arg1),
    .overflow  (overflow)
  );

  always #5 clk_pixel = ~clk_pixel;

  // Monitor: every accepted command must match the head of the scoreboard.
  always @(negedge clk_pixel) begin
    cmd_t got, e;
    if (rst_n && cmd_valid && cmd_ready) begin
      got = '{op: cmd_op, ch: cmd_char, a0: cmd_arg0, a1: cmd_arg1};
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_cmd got op=%0d char=%0h arg0=%0d arg1=%0d", got.op, got.ch, got.a0, got.a1);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL cmd got op=%0d char=%0h arg0=%0d arg1=%0d expected op=%0d char=%0h arg0=%0d arg1=%0d",
                   got.op, got.ch, got.a0, got.a1, e.op, e.ch, e.a0, e.a1);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic expect_cmd(input logic [3:0] op, input logic [6:0] ch, input logic [7:0] a0, input logic [7:0] a1);
    sb.push_back('{op: op, ch: ch, a0: a0, a1: a1});
  endtask

  // Called at posedge+1; drives a one-cycle rx_valid pulse and returns at the next posedge+1.
  task automatic send(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk_pixel);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(8'(s[i]));
  endtask

  task automatic csi(input string s);
    send(B_ESC);
    send_str({"[", s});
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk_pixel);
      #1;
    end
    check({name, "_drained"}, 32'(sb.size()), 32'd0);
    repeat (10) @(posedge clk_pixel);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; cmd_ready = 1'b1;
    repeat (3) @(posedge clk_pixel);
    #1;
    check("rst_valid", 32'(cmd_valid), 32'd0);
    check("rst_fields", {15'd0, cmd_op, cmd_char, cmd_arg0, cmd_arg1}, 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    @(posedge clk_pixel);
    #1;

    // Printable and C0 controls; valid rises two edges after the first pulse.
    expect_cmd(OP_PUT, 7'h41, 8'd0, 8'd0);
    expect_cmd(OP_CR, 7'd0, 8'd0, 8'd0);
    expect_cmd(OP_LF, 7'd0, 8'd0, 8'd0);
    expect_cmd(OP_BS, 7'd0, 8'd0, 8'd0);
    send(8'h41);
    check("lat_not_yet", 32'(cmd_valid), 32'd0);
    send(8'h0D);
    check("lat_valid", 32'(cmd_valid), 32'd1);
    send(8'h0A);
    send(8'h7F);
    drain("ctrl");

    expect_cmd(OP_TAB, 7'd0, 8'd0, 8'd0);
    expect_cmd(OP_HOME, 7'd0, 8'd0, 8'd0);
    expect_cmd(OP_PUT, 7'h7E, 8'd0, 8'd0);
    send(8'h09); send(8'h80); send(8'h01); send(8'h00); send(8'h7E);
    drain("ctrl2");

    // GOTO with clamping and defaults.
    expect_cmd(OP_GOTO, 7'd0, 8'd39, 8'd11);
    expect_cmd(OP_GOTO, 7'd0, 8'd159, 8'd89);
    expect_cmd(OP_GOTO, 7'd0, 8'd0, 8'd0);
    expect_cmd(OP_GOTO, 7'd0, 8'd4, 8'd0);
    csi("12;40H"); csi("200;999H"); csi("H"); csi(";5;7f");
    drain("goto");

    // Cursor moves and clears, with ESC ESC and rejected parameters.
    expect_cmd(OP_MOVE_UP, 7'd0, 8'd3, 8'd0);
    expect_cmd(OP_MOVE_RIGHT, 7'd0, 8'd1, 8'd0);
    expect_cmd(OP_CLEAR, 7'd0, 8'd0, 8'd0);
    expect_cmd(OP_MOVE_DOWN, 7'd0, 8'd1, 8'd0);
    expect_cmd(OP_MOVE_LEFT, 7'd0, 8'd255, 8'd0);
    expect_cmd(OP_CLEAR_EOL, 7'd0, 8'd0, 8'd0);
    csi("3A"); csi("0C"); csi("2J"); csi("1J");
    send(B_ESC); csi("B"); csi("300D"); csi("1K"); csi("K"); csi("5Z");
    drain("csi");

    // Backpressure: first PUT held, sixth byte dropped, DEPTH+1 commands survive.
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) expect_cmd(OP_PUT, 7'(8'h61 + i), 8'd0, 8'd0);
    for (int i = 0; i < 6; i++) send(8'(8'h61 + i));
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", 32'(cmd_valid), 32'd1);
      check("hold_cmd", {21'd0, cmd_op, cmd_char}, {21'd0, OP_PUT, 7'h61});
      @(posedge clk_pixel);
      #1;
    end
    check("overflow_set", 32'(overflow), 32'd1);
    cmd_ready = 1'b1;
    drain("backpressure");
    check("overflow_sticky", 32'(overflow), 32'd1);

    // CAN aborts a partial sequence.
    expect_cmd(OP_PUT, 7'h78, 8'd0, 8'd0);
    csi("3"); send(B_CAN); send(8'h78);
    drain("abort");

    // Reset mid-sequence drops the partial CSI and clears overflow.
    csi("5");
    rst_n = 1'b0;
    #2;
    check("midrst_valid", 32'(cmd_valid), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    @(posedge clk_pixel);
    #1;
    rst_n = 1'b1;
    @(posedge clk_pixel);
    #1;
    expect_cmd(OP_PUT, 7'h42, 8'd0, 8'd0);
    send(8'h42);
    drain("reset");

`ifdef ANSI_SGR_EN
    expect_cmd(OP_COLOR, 7'd0, 8'd1, 8'd0);
    expect_cmd(OP_COLOR, 7'd0, 8'd2, 8'd0);
`endif
    expect_cmd(OP_PUT, 7'h21, 8'd0, 8'd0);
    csi("31m"); csi("m"); csi("40m"); send(8'h21);
    drain("sgr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
